ex_mem_buffer: RTL
==================

Name: ex_mem_buffer

Overview:
- Execute-to-memory pipeline stage directly downstream of the 16-bit ALU.
- Captures the ALU result and flags (R, isZero, isNegative, ovfl) with the instruction's memory/writeback control bits.
- Resolves BIEQ/BINE branches and traps signed overflow.
- Presents entries to the memory stage through a valid/ready handshake, backed by a 2-entry skid buffer so the ready path is registered.

Parameters:
- DW, 16, datapath width (R, store data, branch target)
- RW, 4, destination register index width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  execute stage presents an entry
- in_ready  out  1  buffer can accept; registered
- alu_r  in  DW  ALU result R
- alu_zero  in  1  ALU isZero; already inverted by the ALU for BINE
- alu_neg  in  1  ALU isNegative
- alu_ovfl  in  1  ALU ovfl
- ovfl_chk  in  1  entry is ADD/SUB/SLT; overflow is meaningful
- is_branch  in  1  entry is BIEQ/BINE
- br_target  in  DW  branch destination
- rd  in  RW  destination register
- reg_write, mem_read, mem_write  in  1 each  control bits
- store_data  in  DW  memory write data
- flush  in  1  discard all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage accepts head
- out_r, out_store_data  out  DW  head fields
- out_rd  out  RW  head field
- out_reg_write, out_mem_read, out_mem_write, out_neg  out  1 each  head fields
- br_redirect  out  1  one-cycle pulse, branch taken
- br_pc  out  DW  target qualified by br_redirect
- ovfl_exc  out  1  sticky overflow exception
- exc_clr  in  1  clears ovfl_exc

Behaviour:
- Reset (reset_n=0 at edge): state EMPTY; in_ready=1; out_valid=0; br_redirect=0; ovfl_exc=0; br_pc=0; all out_* data=0. Reset overrides every other input.
- Accept = in_valid & in_ready. Dequeue = out_valid & out_ready.
- Storage: head register plus skid register. States EMPTY / ONE / TWO.
  - EMPTY: accept -> ONE; input written to head.
  - ONE: accept & !dequeue -> TWO, input to skid. !accept & dequeue -> EMPTY. Accept & dequeue -> ONE, input to head.
  - TWO: in_ready=0, so no accept. Dequeue -> ONE, skid moves to head.
- in_ready is registered: 1 in EMPTY and ONE, 0 in TWO.
- Latency: an accepted entry is visible on out_* the next cycle when the buffer was EMPTY, or ONE with a simultaneous dequeue.
- out_valid=1 in ONE and TWO. Head fields stay stable while out_valid & !out_ready.
- Branch: on accept with is_branch & alu_zero, the next cycle has br_redirect=1 and br_pc=br_target for exactly one cycle. Branch entries are stored with all control bits 0.
- Overflow: on accept with ovfl_chk & alu_ovfl:
  - the entry is stored with reg_write=mem_write=mem_read=0 (killed), but still occupies a slot;
  - ovfl_exc is set next cycle and held until exc_clr.
  - Set and exc_clr in the same cycle: set wins.
- out_neg = stored alu_neg, used by the forwarding unit. isZero is not forwarded beyond the branch decision.
- flush=1: next state EMPTY, in_ready=1. Any input offered that cycle is dropped, and a branch or overflow on it is ignored. A br_redirect already registered still completes its pulse. ovfl_exc is unaffected.
- Reset asserted mid-transfer discards all entries. No partial state survives.
- Widths: all data pass through unmodified. No arithmetic performed here.

Decomposition:
- Shared package cpu_pkg:
  - DW and RW constants;
  - buf_state enum (EMPTY, ONE, TWO);
  - ex_entry packed struct {r, store_data, rd, reg_write, mem_read, mem_write, neg}.
- One sub-module, ex_entry_reg: DW/RW-parameterised load-enabled register holding one ex_entry with synchronous active-low clear. Instantiated twice (head, skid).
- Top level holds the FSM, branch and overflow logic.

Test Plan:
- Reset, then single entry alu_r=0x1234, rd=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_r=0x1234, out_rd=3; following cycle out_valid=0.
- Backpressure: out_ready=0, three back-to-back entries 0x0001, 0x0002, 0x0003 -> in_ready drops after the 2nd accept and 0x0003 is held upstream. Releasing out_ready dequeues 1, 2, 3 in order with no loss or duplication.
- Branch: is_branch=1, alu_zero=1, br_target=0x0040 -> br_redirect=1, br_pc=0x0040 for exactly one cycle. Same with alu_zero=0 -> no pulse. Both entries have all out control bits 0.
- Overflow: ovfl_chk=1, alu_ovfl=1, alu_r=0x8000, reg_write=1 -> entry emerges with out_reg_write=0, ovfl_exc=1 and sticky. exc_clr coinciding with a new overflow leaves ovfl_exc=1; exc_clr alone clears it.
- Flush in TWO state with in_valid=1 (in_ready=0) -> next cycle out_valid=0, in_ready=1. No entry ever appears at the output.
- Flush coinciding with in_valid=1 in ONE, carrying a taken branch -> input dropped, no br_redirect, buffer EMPTY.
- reset_n=0 for one cycle while in state TWO -> all outputs return to reset values and no entry appears afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, buffer state encoding and the execute-to-memory entry layout
package cpu_pkg;
  localparam int DW = 16;
  localparam int RW = 4;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state;
  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] store_data;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          neg;
  } ex_entry;
endpackage

// File: rtl/ex_entry_reg.sv
// ex_entry_reg: load-enabled register for one execute-to-memory entry with synchronous active-low clear
module ex_entry_reg #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                en,
  input  logic [2*DW+RW+3:0]  d,
  output logic [2*DW+RW+3:0]  q
);
  // clear wins over load so no stale entry survives reset
  always_ff @(posedge clk)
    if (!clr_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: EX/MEM stage with 2-entry skid buffer, branch resolution and overflow trap
module ex_mem_buffer
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_r,
  input  logic          alu_zero,
  input  logic          alu_neg,
  input  logic          alu_ovfl,
  input  logic          ovfl_chk,
  input  logic          is_branch,
  input  logic [DW-1:0] br_target,
  input  logic [RW-1:0] rd,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [DW-1:0] store_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_store_data,
  output logic [RW-1:0] out_rd,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          out_neg,
  output logic          br_redirect,
  output logic [DW-1:0] br_pc,
  output logic          ovfl_exc,
  input  logic          exc_clr
);
  buf_state state, state_nx;
  ex_entry  in_e, head_d, head_q, skid_q;
  logic     acc, deq, kill, ctl_ok, head_en, skid_en, br_take, ovfl_set;
  assign acc      = in_valid & in_ready & !flush;
  assign deq      = out_valid & out_ready;
  assign kill     = ovfl_chk & alu_ovfl;
  assign ctl_ok   = !kill & !is_branch;
  assign br_take  = acc & is_branch & alu_zero;
  assign ovfl_set = acc & kill;
  assign in_e     = '{r: alu_r, store_data: store_data, rd: rd, reg_write: reg_write & ctl_ok,
                      mem_read: mem_read & ctl_ok, mem_write: mem_write & ctl_ok, neg: alu_neg};
  // next buffer occupancy and which storage slot loads this cycle
  always_comb begin
    state_nx = flush ? EMPTY :
               state == EMPTY ? (acc ? ONE : EMPTY) :
               state == ONE   ? (acc & !deq ? TWO : (!acc & deq ? EMPTY : ONE)) :
                                (deq ? ONE : TWO);
    head_en  = (state == EMPTY & acc) | (state == ONE & acc & deq) | (state == TWO & deq);
    skid_en  = state == ONE & acc & !deq;
    head_d   = state == TWO ? skid_q : in_e;
  end
  ex_entry_reg #(.DW(DW), .RW(RW)) u_head (.clk(CLK), .clr_n(reset_n), .en(head_en), .d(head_d), .q(head_q));
  ex_entry_reg #(.DW(DW), .RW(RW)) u_skid (.clk(CLK), .clr_n(reset_n), .en(skid_en), .d(in_e), .q(skid_q));
  // occupancy, registered ready, branch pulse and sticky overflow flag
  always_ff @(posedge CLK)
    if (!reset_n) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      br_redirect <= 1'b0;
      br_pc       <= '0;
      ovfl_exc    <= 1'b0;
    end else begin
      state       <= state_nx;
      in_ready    <= state_nx != TWO;
      br_redirect <= br_take;
      if (br_take) br_pc <= br_target;
      ovfl_exc    <= ovfl_set | (ovfl_exc & !exc_clr);
    end
  assign out_valid      = state != EMPTY;
  assign out_r          = head_q.r;
  assign out_store_data = head_q.store_data;
  assign out_rd         = head_q.rd;
  assign out_reg_write  = head_q.reg_write;
  assign out_mem_read   = head_q.mem_read;
  assign out_mem_write  = head_q.mem_write;
  assign out_neg        = head_q.neg;
endmodule
